// File: rtl/nios_ii_button_ctrl_if.sv
// Avalon-MM slave bus bundle for the push-button controller.
// A write is accepted on any cycle with chipselect & ~write_n; reads need no
// strobe, and readdata follows address with one clock of latency. There is no
// waitrequest, so every access completes in one cycle.
interface nios_ii_button_ctrl_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/nios_ii_button_ctrl.sv
// Push-button controller: synchronise, debounce and latch press events for
// active-low keys, with a maskable level irq. Optional NIOS_BTN_RAW_READ_EN: raw sync read at address 3.
module nios_ii_button_ctrl #(
   parameter int WIDTH    = 4,
   parameter int TICK_DIV = 50000,
   parameter int DB_COUNT = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   nios_ii_button_ctrl_if.slave  bus,
   input  logic [WIDTH-1:0]      in_port,
   output logic                  irq
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = (DB_COUNT > 1) ? $clog2(DB_COUNT + 1) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

   logic [WIDTH-1:0] sync_q1;
   logic [WIDTH-1:0] sync_q2;
   logic [PW-1:0]    pre_cnt;
   logic             tick;
   logic [WIDTH-1:0] db_state;
   logic [WIDTH-1:0] db_prev;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] w1c;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] edge_cap_nxt;
   logic [WIDTH-1:0] irq_mask;
   logic [31:0]      rd_mux;
   logic [31:0]      readdata_q;
   logic             wr;
   logic             unused_wdata;

   // Synchronisers reset to the released level so reset never looks like a press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q1 <= '1;
         sync_q2 <= '1;
      end else begin
         sync_q1 <= in_port;
         sync_q2 <= sync_q1;
      end
   end

   assign tick = (pre_cnt == PRE_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   // Each line counts ticks of disagreement; any agreement restarts the count.
   for (genvar i = 0; i < WIDTH; i++) begin : g_db
      logic [CW-1:0] db_cnt;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            db_cnt      <= '0;
            db_state[i] <= 1'b1;
         end else if (sync_q2[i] == db_state[i]) begin
            db_cnt <= '0;
         end else if (tick) begin
            if (db_cnt == CNT_LAST) begin
               db_state[i] <= sync_q2[i];
               db_cnt      <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end
      end
   end

   assign wr           = bus.chipselect & ~bus.write_n;
   assign unused_wdata = ^bus.writedata;

   always_comb begin
      fall         = db_prev & ~db_state;
      w1c          = '0;
      if (wr && (bus.address == 2'd2)) begin
         w1c = bus.writedata[WIDTH-1:0];
      end
      // A press landing on the same cycle as its clear must survive.
      edge_cap_nxt = (edge_cap & ~w1c) | fall;
   end

   always_comb begin
      rd_mux = '0;
      case (bus.address)
         2'd0:    rd_mux = 32'(db_state);
         2'd1:    rd_mux = 32'(irq_mask);
         2'd2:    rd_mux = 32'(edge_cap);
`ifdef NIOS_BTN_RAW_READ_EN
         2'd3:    rd_mux = 32'(sync_q2);
`endif
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_prev    <= '1;
         edge_cap   <= '0;
         irq_mask   <= '0;
         readdata_q <= '0;
      end else begin
         db_prev    <= db_state;
         edge_cap   <= edge_cap_nxt;
         readdata_q <= rd_mux;
         if (wr && (bus.address == 2'd1)) begin
            irq_mask <= bus.writedata[WIDTH-1:0];
         end
      end
   end

   assign bus.readdata = readdata_q;
   assign irq          = |(edge_cap & irq_mask);

endmodule
